mult_arbiter: RTL and testbench

Shares one sequential shift-add multiplier between two requesters: the MCU register path (requester 0) and the game/pattern control logic (requester 1). Round-robin arbitration admits one job at a time, runs a fixed-latency OP_W-iteration multiply, and returns the product with the requester ID over a valid/ready response channel. It sits between the AHB slave register block and the multiplier datapath, replacing the single-master start/done strobe.

---
 rtl/mult_arb_pkg.sv | 29 ++
 rtl/mult_shift_add.sv | 96 +++++++++
 rtl/mult_arbiter.sv | 131 +++++++++++++
 tb/tb_mult_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mult_arb_pkg
//  Purpose  : Shared types and helpers for the arbitrated shift-add multiplier.
//             - state_t  : arbiter FSM state encoding (IDLE/LOAD/RUN/DONE)
//             - req_id_t : requester identifier (0 = MCU path, 1 = game logic)
//             - cnt_width: width of an iteration counter able to hold 0..op_w
//  Revision : 1.0 - initial release
// ============================================================================
package mult_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    typedef logic [0:0] req_id_t;

    localparam req_id_t REQ0 = 1'b0;
    localparam req_id_t REQ1 = 1'b1;

    function automatic int cnt_width(input int op_w);
        return $clog2(op_w + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mult_shift_add.sv
`default_nettype none
// ============================================================================
//  Module   : mult_shift_add
//  Purpose  : Fixed-latency sequential shift-add multiplier core.
//             load : capture operand magnitudes and result sign, clear the
//                    accumulator and iteration counter (one cycle).
//             step : one shift-add iteration, multiplier LSB first.
//             last : current step is the final (OP_W-th) iteration.
//             result: sign-corrected product as it will stand after the
//                    current step; valid to capture on the edge where
//                    step && last.
//  Ports    : clk, rst (sync, active-high), load, step, a, b, last, result
//  Config   : MULT_ARB_SIGNED_EN - two's complement operands/product when
//             defined, unsigned otherwise.
//  Revision : 1.0 - initial release
// ============================================================================
module mult_shift_add
    import mult_arb_pkg::*;
#(
    parameter int OP_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic                step,
    input  logic [OP_W-1:0]     a,
    input  logic [OP_W-1:0]     b,
    output logic                last,
    output logic [2*OP_W-1:0]   result
);

    localparam int                 CNT_W       = cnt_width(OP_W);
    localparam logic [CNT_W-1:0]   C_CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]   C_CNT_LAST  = CNT_W'(OP_W - 1);
    localparam logic [2*OP_W-1:0]  C_PROD_ONE  = {{(2*OP_W-1){1'b0}}, 1'b1};

    logic [2*OP_W-1:0] r_acc;
    logic [2*OP_W-1:0] r_mcand;
    logic [OP_W-1:0]   r_mplier;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_neg;

    logic [OP_W-1:0]   w_mag_a;
    logic [OP_W-1:0]   w_mag_b;
    logic              w_neg;
    logic [2*OP_W-1:0] w_addend;
    logic [2*OP_W-1:0] w_acc_next;

`ifdef MULT_ARB_SIGNED_EN
    localparam logic [OP_W-1:0] C_OP_ONE = {{(OP_W-1){1'b0}}, 1'b1};

    // The magnitude of the most negative value still fits in OP_W unsigned
    // bits, so no extra guard bit is needed.
    always_comb begin
        w_mag_a = a[OP_W-1] ? ((~a) + C_OP_ONE) : a;
        w_mag_b = b[OP_W-1] ? ((~b) + C_OP_ONE) : b;
        w_neg   = a[OP_W-1] ^ b[OP_W-1];
    end
`else
    always_comb begin
        w_mag_a = a;
        w_mag_b = b;
        w_neg   = 1'b0;
    end
`endif

    always_comb begin
        w_addend   = r_mplier[0] ? r_mcand : '0;
        w_acc_next = r_acc + w_addend;
        result     = r_neg ? ((~w_acc_next) + C_PROD_ONE) : w_acc_next;
        last       = (r_cnt == C_CNT_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_neg    <= 1'b0;
        end else if (load) begin
            r_acc    <= '0;
            r_mcand  <= {{OP_W{1'b0}}, w_mag_a};
            r_mplier <= w_mag_b;
            r_cnt    <= '0;
            r_neg    <= w_neg;
        end else if (step) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + C_CNT_ONE;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mult_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mult_arbiter
//  Purpose  : Round-robin sharing of one sequential multiplier between two
//             requesters, with a valid/ready response channel.
//  Ports    : AHB_HCLK, AHB_HRESET (sync, active-high)
//             req0_valid/req0_a/req0_b/req0_ready  - requester 0 (MCU path)
//             req1_valid/req1_a/req1_b/req1_ready  - requester 1 (game logic)
//             rsp_valid/rsp_ready/rsp_id/rsp_product - result channel
//             busy - high whenever a job is in flight or awaiting pickup
//  Config   : MULT_ARB_SIGNED_EN - signed operands/product when defined.
//  Timing   : accept cycle 0, LOAD cycle 1, RUN cycles 2..OP_W+1,
//             rsp_valid from cycle OP_W+2 until the handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int OP_W = 8
) (
    input  logic                AHB_HCLK,
    input  logic                AHB_HRESET,
    input  logic                req0_valid,
    input  logic [OP_W-1:0]     req0_a,
    input  logic [OP_W-1:0]     req0_b,
    output logic                req0_ready,
    input  logic                req1_valid,
    input  logic [OP_W-1:0]     req1_a,
    input  logic [OP_W-1:0]     req1_b,
    output logic                req1_ready,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_id,
    output logic [2*OP_W-1:0]   rsp_product,
    output logic                busy
);

    state_t            r_state;
    req_id_t           r_last_grant;
    req_id_t           r_job_id;
    req_id_t           r_rsp_id;
    logic [OP_W-1:0]   r_op_a;
    logic [OP_W-1:0]   r_op_b;
    logic [2*OP_W-1:0] r_rsp_product;

    logic              w_idle;
    logic              w_grant0;
    logic              w_grant1;
    logic              w_last;
    logic [2*OP_W-1:0] w_result;

    // Grants are suppressed while reset is asserted so that a requester
    // never sees an acceptance that the reset is about to discard.
    always_comb begin
        w_idle   = (r_state == ST_IDLE) && !AHB_HRESET;
        w_grant0 = w_idle && req0_valid && (!req1_valid || (r_last_grant == REQ1));
        w_grant1 = w_idle && req1_valid && !w_grant0;
    end

    assign req0_ready  = w_grant0;
    assign req1_ready  = w_grant1;
    assign rsp_valid   = (r_state == ST_DONE);
    assign busy        = (r_state != ST_IDLE);
    assign rsp_id      = r_rsp_id;
    assign rsp_product = r_rsp_product;

    always_ff @(posedge AHB_HCLK) begin
        if (AHB_HRESET) begin
            r_state       <= ST_IDLE;
            r_last_grant  <= REQ1;
            r_job_id      <= REQ0;
            r_rsp_id      <= REQ0;
            r_op_a        <= '0;
            r_op_b        <= '0;
            r_rsp_product <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant0) begin
                        r_op_a       <= req0_a;
                        r_op_b       <= req0_b;
                        r_job_id     <= REQ0;
                        r_last_grant <= REQ0;
                        r_state      <= ST_LOAD;
                    end else if (w_grant1) begin
                        r_op_a       <= req1_a;
                        r_op_b       <= req1_b;
                        r_job_id     <= REQ1;
                        r_last_grant <= REQ1;
                        r_state      <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_state <= ST_RUN;
                end
                ST_RUN: begin
                    // The core's result already includes the final step, so
                    // it is captured on the same edge that enters DONE.
                    if (w_last) begin
                        r_rsp_product <= w_result;
                        r_rsp_id      <= r_job_id;
                        r_state       <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (rsp_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    mult_shift_add #(
        .OP_W   (OP_W)
    ) u_core (
        .clk    (AHB_HCLK),
        .rst    (AHB_HRESET),
        .load   (r_state == ST_LOAD),
        .step   (r_state == ST_RUN),
        .a      (r_op_a),
        .b      (r_op_b),
        .last   (w_last),
        .result (w_result)
    );

endmodule
`default_nettype wire

// File: tb/tb_mult_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mult_arbiter
//  Purpose  : Self-checking bench for mult_arbiter (OP_W = 8). Table-driven
//             single jobs plus hand-written round-robin, backpressure and
//             reset-abort sequences; a scoreboard checks every response.
//  Config   : MULT_ARB_SIGNED_EN selects the signed vector table/model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mult_arbiter;

    localparam int OP_W = 8;

    logic              clk = 1'b0;
    logic              AHB_HRESET;
    logic              req0_valid, req1_valid;
    logic [OP_W-1:0]   req0_a, req0_b, req1_a, req1_b;
    logic              req0_ready, req1_ready;
    logic              rsp_valid, rsp_ready, rsp_id, busy;
    logic [2*OP_W-1:0] rsp_product;

    mult_arbiter #(.OP_W(OP_W)) dut (
        .AHB_HCLK    (clk),
        .AHB_HRESET  (AHB_HRESET),
        .req0_valid  (req0_valid),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .req1_ready  (req1_ready),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_product (rsp_product),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_bad = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b);
`ifdef MULT_ARB_SIGNED_EN
        logic signed [15:0] p;
        p = $signed(a) * $signed(b);
        return p;
`else
        return {8'd0, a} * {8'd0, b};
`endif
    endfunction

    // ---------------- scoreboard and accept log --------------------------
    typedef struct {
        logic        id;
        logic [15:0] prod;
    } exp_t;

    exp_t sb[$];
    int   acc_ids[$];
    int   acc_cycs[$];

    always @(negedge clk) begin
        if (req0_valid && req0_ready) begin
            sb.push_back('{1'b0, model(req0_a, req0_b)});
            acc_ids.push_back(0);
            acc_cycs.push_back(cyc);
        end
        if (req1_valid && req1_ready) begin
            sb.push_back('{1'b1, model(req1_a, req1_b)});
            acc_ids.push_back(1);
            acc_cycs.push_back(cyc);
        end
        if (rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_rsp", 32'(rsp_product), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_id", 32'(rsp_id), 32'(e.id));
                chk("sb_product", 32'(rsp_product), 32'(e.prod));
            end
        end
    end

    // ---------------- vector table ---------------------------------------
    typedef struct {
        int          id;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl[8];

    task automatic do_reset();
        AHB_HRESET = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        AHB_HRESET = 1'b0;
    endtask

    // One complete job on the chosen requester with rsp_ready held high.
    task automatic run_job(input int id, input logic [7:0] a, input logic [7:0] b,
                           input logic [15:0] exp);
        bit got;
        int t_acc;
        rsp_ready = 1'b1;
        if (id == 0) begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
        else         begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
        got = 0;
        t_acc = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            #2;
            if ((id == 0 && req0_ready) || (id == 1 && req1_ready)) begin
                got = 1;
                t_acc = cyc;
            end
            @(posedge clk); #1;
        end
        chk("accept_seen", 32'(got), 32'd1);
        // Operands change right after the accept edge; the result must not.
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = 8'($urandom); req0_b = 8'($urandom);
        req1_a = 8'($urandom); req1_b = 8'($urandom);
        got = 0;
        for (int i = 0; i < 30 && !got; i++) begin
            if (rsp_valid) got = 1;
            else begin @(posedge clk); #1; end
        end
        chk("rsp_seen", 32'(got), 32'd1);
        if (got) begin
            chk("latency", 32'(cyc - t_acc), 32'd10);
            chk("tbl_product", 32'(rsp_product), 32'(exp));
            chk("tbl_id", 32'(rsp_id), 32'(id));
        end
        @(posedge clk); #1;
        chk("idle_after_rsp", 32'({busy, rsp_valid}), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        int t0;
        int base;

`ifdef MULT_ARB_SIGNED_EN
        tbl[0] = '{1, 8'hFD, 8'h07, 16'hFFEB};
        tbl[1] = '{0, 8'h80, 8'h80, 16'h4000};
        tbl[2] = '{0, 8'h00, 8'hC8, 16'h0000};
        tbl[3] = '{1, 8'h7F, 8'h7F, 16'h3F01};
        tbl[4] = '{0, 8'hFF, 8'h01, 16'hFFFF};
        tbl[5] = '{1, 8'h80, 8'h7F, 16'hC080};
        tbl[6] = '{0, 8'hFE, 8'hFE, 16'h0004};
        tbl[7] = '{1, 8'h0C, 8'hF6, 16'hFF88};
`else
        tbl[0] = '{0, 8'd255, 8'd255, 16'd65025};
        tbl[1] = '{1, 8'd0,   8'd200, 16'd0};
        tbl[2] = '{1, 8'd3,   8'd7,   16'd21};
        tbl[3] = '{0, 8'd16,  8'd16,  16'd256};
        tbl[4] = '{1, 8'd1,   8'd255, 16'd255};
        tbl[5] = '{0, 8'd128, 8'd2,   16'd256};
        tbl[6] = '{0, 8'd200, 8'd0,   16'd0};
        tbl[7] = '{1, 8'd170, 8'd85,  16'd14450};
`endif

        req0_valid = 0; req1_valid = 0;
        req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
        rsp_ready = 0;

        // ---- reset state ----
        do_reset();
        chk("rst_ready0",  32'(req0_ready),  32'd0);
        chk("rst_ready1",  32'(req1_ready),  32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_id",  32'(rsp_id),      32'd0);
        chk("rst_product", 32'(rsp_product), 32'd0);
        chk("rst_busy",    32'(busy),        32'd0);

        // ---- table-driven single jobs ----
        for (int i = 0; i < 8; i++) begin
            run_job(tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].exp);
        end

        // ---- backpressure ----
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 8'd12; req0_b = 8'd13;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            if (rsp_valid) seen = 1;
            else begin @(posedge clk); #1; end
        end
        chk("bp_rsp_seen", 32'(seen), 32'd1);
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = 8'd1; req0_b = 8'd1; req1_a = 8'd2; req1_b = 8'd2;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            chk("bp_hold", 32'({rsp_valid, busy, req0_ready, req1_ready, rsp_id}), 32'b11000);
            chk("bp_product", 32'(rsp_product), 32'd156);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_idle", 32'({busy, rsp_valid}), 32'd0);

        // ---- round robin with both valid continuously after reset ----
        do_reset();
        acc_ids.delete(); acc_cycs.delete();
        req0_valid = 1'b1; req0_a = 8'd5; req0_b = 8'd6;
        req1_valid = 1'b1; req1_a = 8'd9; req1_b = 8'd10;
        for (int i = 0; i < 80 && acc_ids.size() < 4; i++) begin
            @(posedge clk); #1;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("rr_accepts", 32'(acc_ids.size()), 32'd4);
        if (acc_ids.size() >= 4) begin
            for (int i = 0; i < 4; i++) chk("rr_grant", 32'(acc_ids[i]), 32'(i % 2));
            for (int i = 1; i < 4; i++) chk("rr_spacing", 32'(acc_cycs[i] - acc_cycs[i-1]), 32'd11);
        end
        seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(posedge clk); #1;
            if (!busy) seen = 1;
        end
        chk("rr_drain", 32'(seen), 32'd1);
        chk("rr_last_id", 32'(rsp_id), 32'd1);

        // ---- reset during RUN aborts the job ----
        req0_valid = 1'b1; req0_a = 8'd21; req0_b = 8'd3;
        #2;
        t0 = cyc;
        chk("abort_accept", 32'(req0_ready), 32'd1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        while (cyc < t0 + 6) begin @(posedge clk); #1; end
        chk("abort_busy_in_run", 32'(busy), 32'd1);
        AHB_HRESET = 1'b1;
        @(posedge clk); #1;
        AHB_HRESET = 1'b0;
        chk("abort_outputs", 32'({req0_ready, req1_ready, rsp_valid, rsp_id, busy}), 32'd0);
        chk("abort_product", 32'(rsp_product), 32'd0);
        sb.delete();
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (rsp_valid) seen = 1;
        end
        chk("abort_no_rsp", 32'(seen), 32'd0);

        // ---- first tie after reset goes to requester 0 ----
        base = acc_ids.size();
        req0_valid = 1'b1; req0_a = 8'd7; req0_b = 8'd8;
        req1_valid = 1'b1; req1_a = 8'd4; req1_b = 8'd4;
        #2;
        chk("tie_ready", 32'({req0_ready, req1_ready}), 32'b10);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("tie_logged", 32'(acc_ids.size() - base), 32'd1);
        seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(posedge clk); #1;
            if (!busy) seen = 1;
        end
        chk("tie_drain", 32'(seen), 32'd1);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
